// File: rtl/latch_wr_ctrl.sv
// rtl/latch_wr_ctrl.sv - handshake-to-latch write strobe generator with programmable setup/pulse/hold.
// Optional readback compare and error counter enabled by LATCH_WR_READBACK_EN.
module latch_wr_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
`ifdef LATCH_WR_READBACK_EN
  input  logic [WIDTH-1:0] lat_q,
  output logic             err,
  output logic [7:0]       err_cnt,
`endif
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy
);

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic             in_ready_nxt;
  logic             busy_nxt;
  logic             lat_en_nxt;
  logic [WIDTH-1:0] lat_d_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Every output is computed one cycle ahead so the latch pins come straight from flops.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_ready_nxt = in_ready;
    busy_nxt     = busy;
    lat_en_nxt   = lat_en;
    lat_d_nxt    = lat_d;
    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
        lat_en_nxt   = 1'b0;
        if (in_valid && in_ready) begin
          lat_d_nxt    = in_data;
          state_nxt    = SETUP;
          cnt_nxt      = SETUP_LD;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt  = PULSE;
          cnt_nxt    = PULSE_LD;
          lat_en_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          state_nxt  = HOLD;
          cnt_nxt    = HOLD_LD;
          lat_en_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt    = IDLE;
          cnt_nxt      = 8'd0;
          in_ready_nxt = 1'b1;
          busy_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        cnt_nxt      = 8'd0;
        in_ready_nxt = 1'b0;
        busy_nxt     = 1'b0;
        lat_en_nxt   = 1'b0;
      end
    endcase
  end

  // Async clear drops lat_en at once so a partial write never leaves a latch open.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      lat_en   <= 1'b0;
      lat_d    <= '0;
    end else begin
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
      lat_en   <= lat_en_nxt;
      lat_d    <= lat_d_nxt;
    end
  end

`ifdef LATCH_WR_READBACK_EN
  logic hold_last;
  logic mismatch;

  always_comb begin
    hold_last = (state == HOLD) && (cnt == 8'd0);
    mismatch  = hold_last && (lat_q != lat_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= mismatch;
      if (mismatch && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// tb/tb_latch_wr_ctrl.sv - randomized bench for latch_wr_ctrl at three timing corners against a cycle-window model.
module tb_latch_wr_ctrl;
  localparam int W = 8;
  localparam int N = 3;
  localparam int S_C[N] = '{2, 1, 255};
  localparam int P_C[N] = '{3, 1, 255};
  localparam int H_C[N] = '{1, 1, 255};
  localparam int IDLE_REL = 1000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0]        in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic [N-1:0][W-1:0] lat_d;
  logic [N-1:0]        lat_en;
  logic [N-1:0]        busy;
`ifdef LATCH_WR_READBACK_EN
  logic [N-1:0][W-1:0] lat_q;
  logic [N-1:0]        err;
  logic [N-1:0][7:0]   err_cnt;
  logic [N-1:0][W-1:0] mask;
  always_comb begin
    for (int i = 0; i < N; i++) lat_q[i] = lat_d[i] ^ mask[i];
  end
`endif

  always #5 clk = ~clk;

  latch_wr_ctrl #(.WIDTH(W), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
`ifdef LATCH_WR_READBACK_EN
    .lat_q(lat_q[0]), .err(err[0]), .err_cnt(err_cnt[0]),
`endif
    .lat_d(lat_d[0]), .lat_en(lat_en[0]), .busy(busy[0]));

  latch_wr_ctrl #(.WIDTH(W), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
`ifdef LATCH_WR_READBACK_EN
    .lat_q(lat_q[1]), .err(err[1]), .err_cnt(err_cnt[1]),
`endif
    .lat_d(lat_d[1]), .lat_en(lat_en[1]), .busy(busy[1]));

  latch_wr_ctrl #(.WIDTH(W), .SETUP_CYC(255), .PULSE_CYC(255), .HOLD_CYC(255)) u_dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
`ifdef LATCH_WR_READBACK_EN
    .lat_q(lat_q[2]), .err(err[2]), .err_cnt(err_cnt[2]),
`endif
    .lat_d(lat_d[2]), .lat_en(lat_en[2]), .busy(busy[2]));

  int checks = 0;
  int failures = 0;

  // Reference: cycles since acceptance (rel) plus the written word; outputs are timing windows on rel.
  int         rel[N];
  logic [W-1:0] word[N];
  bit         armed;
  int         acc_cnt[N];
  int         last_acc[N];
  int         prev_acc[N];
  int         cyc = 0;
  bit         mism[N];
  int         exp_cnt[N];
  logic [N-1:0]        drv_v;
  logic [N-1:0][W-1:0] drv_d;
  bit         force_mask = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_en(int i);
    return (rel[i] >= 1 + S_C[i]) && (rel[i] <= S_C[i] + P_C[i]);
  endfunction

  function automatic logic exp_busy(int i);
    return (rel[i] >= 1) && (rel[i] <= S_C[i] + P_C[i] + H_C[i]);
  endfunction

  function automatic logic exp_ready(int i);
    return armed && (rel[i] >= 1 + S_C[i] + P_C[i] + H_C[i]);
  endfunction

  task automatic model_reset();
    armed = 1'b0;
    for (int i = 0; i < N; i++) begin
      rel[i] = IDLE_REL;
      word[i] = '0;
      exp_cnt[i] = 0;
      mism[i] = 1'b0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("in_ready%0d", i), in_ready[i], exp_ready(i));
      chk($sformatf("lat_en%0d", i), lat_en[i], exp_en(i));
      chk($sformatf("busy%0d", i), busy[i], exp_busy(i));
      chk($sformatf("lat_d%0d", i), lat_d[i], word[i]);
`ifdef LATCH_WR_READBACK_EN
      chk($sformatf("err%0d", i), err[i],
          (rel[i] == 1 + S_C[i] + P_C[i] + H_C[i]) && mism[i]);
      chk($sformatf("err_cnt%0d", i), err_cnt[i], exp_cnt[i]);
`endif
    end
    for (int i = 0; i < N; i++) begin
      in_valid[i] = drv_v[i];
      in_data[i]  = drv_d[i];
      acc[i] = drv_v[i] && exp_ready(i);
`ifdef LATCH_WR_READBACK_EN
      if (acc[i]) begin
        if (force_mask) mask[i] = 8'hff;
        else mask[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : W'($urandom_range(1, 255));
      end
`endif
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rel[i] = 1;
        word[i] = drv_d[i];
        acc_cnt[i]++;
        prev_acc[i] = last_acc[i];
        last_acc[i] = cyc;
`ifdef LATCH_WR_READBACK_EN
        mism[i] = (mask[i] != 8'h00);
`endif
      end else if (rel[i] < IDLE_REL) begin
        rel[i]++;
        if (rel[i] == 1 + S_C[i] + P_C[i] + H_C[i] && mism[i] && exp_cnt[i] < 255) exp_cnt[i]++;
      end
    end
    armed = 1'b1;
  endtask

  task automatic assert_reset();
    #2 rstn = 1'b0;
    in_valid = '0;
    drv_v = '0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_lat_en%0d", i), lat_en[i], 1'b0);
      chk($sformatf("rst_lat_d%0d", i), lat_d[i], '0);
      chk($sformatf("rst_in_ready%0d", i), in_ready[i], 1'b0);
      chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_acc(input int i, input int target, input int bound);
    int n = 0;
    while (acc_cnt[i] < target && n < bound) begin
      tick();
      n++;
    end
    chk($sformatf("acc_timeout%0d", i), acc_cnt[i] >= target, 1'b1);
  endtask

  initial begin
    int base;
    int n;
    in_valid = '0;
    in_data = '0;
    drv_v = '0;
    drv_d = '0;
`ifdef LATCH_WR_READBACK_EN
    mask = '0;
`endif
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0;
      last_acc[i] = 0;
      prev_acc[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    assert_reset();

    // basic write
    drv_v[0] = 1'b1;
    drv_d[0] = 8'hA5;
    wait_acc(0, 1, 10);
    drv_v[0] = 1'b0;
    repeat (10) tick();

    // back-to-back with valid held and data changing during the first write
    base = acc_cnt[0];
    drv_v[0] = 1'b1;
    drv_d[0] = 8'h11;
    n = 0;
    while (acc_cnt[0] < base + 2 && n < 30) begin
      if (acc_cnt[0] > base) drv_d[0] = (rel[0] == 7) ? 8'h22 : W'($urandom);
      tick();
      n++;
    end
    chk("b2b_done", acc_cnt[0], base + 2);
    chk("b2b_gap", last_acc[0] - prev_acc[0], 7);
    chk("b2b_word", word[0], 8'h22);
    drv_v[0] = 1'b0;
    repeat (10) tick();

    // reset during PULSE
    drv_v[0] = 1'b1;
    drv_d[0] = 8'h5A;
    wait_acc(0, acc_cnt[0] + 1, 10);
    drv_v[0] = 1'b0;
    n = 0;
    while (rel[0] != 4 && n < 20) begin
      tick();
      n++;
    end
    #1 chk("pre_rst_lat_en", lat_en[0], 1'b1);
    assert_reset();
    drv_v[0] = 1'b1;
    drv_d[0] = 8'h3C;
    wait_acc(0, acc_cnt[0] + 1, 10);
    drv_v[0] = 1'b0;
    repeat (10) tick();

    // randomized traffic on all three corners
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        drv_v[i] = ($urandom_range(0, 2) != 0);
        drv_d[i] = W'($urandom);
      end
      tick();
    end
    drv_v = '0;

`ifdef LATCH_WR_READBACK_EN
    // hammer the fast corner with failing readbacks until the counter saturates
    force_mask = 1'b1;
    drv_v[1] = 1'b1;
    drv_d[1] = 8'hff;
    repeat (1100) tick();
    drv_v[1] = 1'b0;
    repeat (6) tick();
    chk("err_cnt_sat", err_cnt[1], 8'hff);
`endif
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
